// File: rtl/rv32_defs_pkg.sv
// Shared RV32 definitions for the fetch stage and the control unit.
//   NOP_INSTR     canonical bubble (ADDI x0,x0,0)
//   OP_*          major opcode constants
//   fetch_state_e fetch FSM encoding
//   if_id_t       IF/ID pipeline register contents
//   align_pc()    clears the two low address bits of a jump/branch target
package rv32_defs_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture d (new instruction)
//   flush       replace the instruction with a NOP bubble (wins over load)
//   d, q        register input / contents
// With neither load nor flush asserted the register holds (stall).
module if_id_register
    import rv32_defs_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else if (flush) begin
            // PC of a bubble is meaningless; keep it to avoid extra toggling.
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the RV32IM pipeline: owns the PC, drives instruction memory,
// and holds the IF/ID register with its decoded fields.
//   clk, reset           clock, asynchronous active-low reset
//   stall                hold PC and IF/ID
//   redirect, target     taken branch/jump from EX (target low bits ignored)
//   imem_addr/read       instruction memory request (address = PC)
//   imem_data/busy       memory response; word valid when read && !busy
//   fetch_busy           fetch is waiting on memory (WAIT or DRAIN)
//   if_id_*              IF/ID contents; pc4 is the link value
//   opcode..rs2          combinational slices of if_id_instr
module instruction_fetch
    import rv32_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_data,
    input  logic        imem_busy,
    output logic        fetch_busy,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         ifid_load, ifid_flush;
    logic [31:0]  redirect_pc;
    if_id_t       ifid_d, ifid_q;

    assign redirect_pc = align_pc(target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // One cycle with no request after reset, then start fetching.
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    if (imem_busy) begin
                        state_d    = ST_WAIT;
                        ifid_flush = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem_busy) begin
                        // Access still in flight: finish it at the old PC first.
                        target_d = redirect_pc;
                        state_d  = ST_DRAIN;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = ST_FETCH;
                    end
                end else if (!stall && !imem_busy) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (imem_busy) begin
                        target_d = redirect_pc;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = ST_FETCH;
                    end
                end else if (!stall && !imem_busy) begin
                    // Stale word is dropped; IF/ID already holds a bubble.
                    pc_d    = target_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ifid_d = '{pc: pc_q, instr: imem_data, valid: 1'b1};

    if_id_register u_if_id (
        .clk   (clk),
        .rst_n (reset),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr   = pc_q;
    assign imem_read   = (state_q != ST_IDLE);
    assign fetch_busy  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    assign if_id_pc    = ifid_q.pc;
    assign if_id_pc4   = ifid_q.pc + 32'd4;
    assign if_id_instr = ifid_q.instr;
    assign if_id_valid = ifid_q.valid;

    assign opcode = ifid_q.instr[6:0];
    assign func3  = ifid_q.instr[14:12];
    assign func7  = ifid_q.instr[31:25];
    assign rd     = ifid_q.instr[11:7];
    assign rs1    = ifid_q.instr[19:15];
    assign rs2    = ifid_q.instr[24:20];

endmodule
